// File: rtl/uart_frame_ctrl.sv
// Turns the UART receiver byte stream into checksum-validated 64-bit price frames.
// Accepted frames go out on a valid/ready register; good and error counts are kept.
module uart_frame_ctrl #(
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         BAUD         = 115200,
  parameter int         TIMEOUT_BITS = 20,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_frame_err,
  output logic [63:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        crc_err,
  output logic        timeout_err,
  output logic        link_err,
  output logic        overflow_err,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
);

  localparam int TIMEOUT_CYC = TIMEOUT_BITS * (CLK_HZ / BAUD);
  localparam int TW          = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  function automatic logic [7:0] xor_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_idx;
  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_xor;
  logic [63:0]     r_shift;
  logic [63:0]     r_frame_data;
  logic            r_frame_valid;
  logic            r_crc_err;
  logic            r_timeout_err;
  logic            r_link_err;
  logic            r_overflow_err;
  logic [15:0]     r_good_cnt;
  logic [15:0]     r_err_cnt;

  logic            w_tmo_term;
  logic            w_start;
  logic            w_take;
  logic            w_commit;
  logic            w_crc;
  logic            w_tmo;
  logic            w_link;
  logic            w_load;
  logic            w_ovf;
  logic            w_xfer;
  logic            w_err_any;

  // Next-state decode plus one-cycle event strobes for the datapath and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_take      = 1'b0;
    w_commit    = 1'b0;
    w_crc       = 1'b0;
    w_tmo       = 1'b0;
    w_link      = 1'b0;
    w_tmo_term  = (r_tmo == TMO_LAST);
    case (r_state)
      HUNT: begin
        if (rx_valid && !rx_frame_err && (rx_byte == SYNC_BYTE)) begin
          w_start     = 1'b1;
          w_state_nxt = PAYLOAD;
        end else begin
          w_state_nxt = HUNT;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          if (rx_frame_err) begin
            w_link      = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_take      = 1'b1;
            w_state_nxt = (r_idx == 3'd7) ? CHECK : PAYLOAD;
          end
        end else if (w_tmo_term) begin
          w_tmo       = 1'b1;
          w_state_nxt = HUNT;
        end else begin
          w_state_nxt = PAYLOAD;
        end
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_frame_err) begin
            w_link = 1'b1;
          end else if (rx_byte == r_xor) begin
            w_commit = 1'b1;
          end else begin
            w_crc = 1'b1;
          end
          w_state_nxt = HUNT;
        end else if (w_tmo_term) begin
          w_tmo       = 1'b1;
          w_state_nxt = HUNT;
        end else begin
          w_state_nxt = CHECK;
        end
      end
      default: begin
        w_state_nxt = HUNT;
      end
    endcase
  end

  // A new frame may replace the held one only if the consumer takes the old one this cycle
  always_comb begin
    w_xfer    = r_frame_valid && frame_ready;
    w_load    = w_commit && (!r_frame_valid || frame_ready);
    w_ovf     = w_commit && r_frame_valid && !frame_ready;
    w_err_any = w_crc || w_tmo || w_link || w_ovf;
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Payload assembly, running checksum and inter-byte timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= 3'd0;
      r_tmo   <= '0;
      r_xor   <= 8'h00;
      r_shift <= 64'h0;
    end else begin
      if (w_state_nxt == HUNT || rx_valid) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_start) begin
        r_idx <= 3'd0;
        r_xor <= 8'h00;
      end else if (w_take) begin
        r_shift <= {r_shift[55:0], rx_byte};
        r_xor   <= xor_acc(r_xor, rx_byte);
        r_idx   <= r_idx + 3'd1;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  // Output frame register, error pulses and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_data   <= 64'h0;
      r_frame_valid  <= 1'b0;
      r_crc_err      <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_link_err     <= 1'b0;
      r_overflow_err <= 1'b0;
      r_good_cnt     <= 16'd0;
      r_err_cnt      <= 16'd0;
    end else begin
      if (w_load) begin
        r_frame_data  <= r_shift;
        r_frame_valid <= 1'b1;
        r_good_cnt    <= r_good_cnt + 16'd1;
      end else if (w_xfer) begin
        r_frame_valid <= 1'b0;
      end else begin
        r_frame_valid <= r_frame_valid;
      end
      r_crc_err      <= w_crc;
      r_timeout_err  <= w_tmo;
      r_link_err     <= w_link;
      r_overflow_err <= w_ovf;
      if (w_err_any) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  assign frame_data   = r_frame_data;
  assign frame_valid  = r_frame_valid;
  assign crc_err      = r_crc_err;
  assign timeout_err  = r_timeout_err;
  assign link_err     = r_link_err;
  assign overflow_err = r_overflow_err;
  assign good_cnt     = r_good_cnt;
  assign err_cnt      = r_err_cnt;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frames plus randomized traffic, all outputs
// compared every cycle against a byte-list reference model.
module tb_uart_frame_ctrl;

  localparam int TMO = 20 * (50_000_000 / 115200);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_frame_err = 1'b0;
  logic        frame_ready = 1'b0;
  logic [63:0] frame_data;
  logic        frame_valid;
  logic        crc_err;
  logic        timeout_err;
  logic        link_err;
  logic        overflow_err;
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;

  uart_frame_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .crc_err      (crc_err),
    .timeout_err  (timeout_err),
    .link_err     (link_err),
    .overflow_err (overflow_err),
    .good_cnt     (good_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_in;
  logic [7:0]  m_q[$];
  int          m_idle;
  bit          m_hv;
  logic [63:0] m_hd;
  bit          e_crc, e_tmo, e_link, e_ovf;
  logic [15:0] m_good, m_err;

  task automatic m_reset();
    m_in = 0; m_q.delete(); m_idle = 0; m_hv = 0; m_hd = 64'h0;
    e_crc = 0; e_tmo = 0; e_link = 0; e_ovf = 0; m_good = 16'd0; m_err = 16'd0;
  endtask

  task automatic m_step();
    bit commit;
    logic [7:0] x;
    commit = 0;
    e_crc = 0; e_tmo = 0; e_link = 0; e_ovf = 0;
    if (!m_in) begin
      if (rx_valid && !rx_frame_err && rx_byte == 8'hA5) begin
        m_in = 1; m_q.delete(); m_idle = 0;
      end
    end else if (rx_valid) begin
      m_idle = 0;
      if (rx_frame_err) begin
        e_link = 1; m_in = 0;
      end else if (m_q.size() < 8) begin
        m_q.push_back(rx_byte);
      end else begin
        x = 8'h00;
        foreach (m_q[i]) x = x ^ m_q[i];
        if (x == rx_byte) commit = 1; else e_crc = 1;
        m_in = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        e_tmo = 1; m_in = 0;
      end
    end
    if (commit) begin
      if (!m_hv || frame_ready) begin
        m_hv = 1;
        m_hd = 64'h0;
        for (int i = 0; i < 8; i++) m_hd = {m_hd[55:0], m_q[i]};
        m_good = m_good + 16'd1;
      end else begin
        e_ovf = 1;
      end
    end else if (m_hv && frame_ready) begin
      m_hv = 0;
    end
    m_err = m_err + 16'(e_crc) + 16'(e_tmo) + 16'(e_link) + 16'(e_ovf);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  // Every-cycle comparison, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("frame_valid", frame_valid, m_hv);
        chk("frame_data", frame_data, m_hd);
        chk("crc_err", crc_err, e_crc);
        chk("timeout_err", timeout_err, e_tmo);
        chk("link_err", link_err, e_link);
        chk("overflow_err", overflow_err, e_ovf);
        chk("good_cnt", good_cnt, m_good);
        chk("err_cnt", err_cnt, m_err);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) frame_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    rx_byte = b; rx_valid = 1'b1; rx_frame_err = fe;
    step();
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] p, input logic [7:0] ck);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 8; i++) send_byte(p[63-8*i -: 8], 1'b0);
    send_byte(ck, 1'b0);
  endtask

  function automatic logic [7:0] xsum(input logic [63:0] p);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 8; i++) x = x ^ p[8*i +: 8];
    return x;
  endfunction

  localparam logic [63:0] F1 = 64'h0102030405060708;
  localparam logic [63:0] F2 = 64'h1020304050607080;

  initial begin
    int kind, pos, gap, long_left;
    logic [63:0] p;
    logic [7:0] ck;
    #1 reset = 1'b0;
    #3;
    chk("reset_valid", frame_valid, 1'b0);
    chk("reset_data", frame_data, 64'h0);
    chk("reset_good", good_cnt, 16'd0);
    chk("reset_err", err_cnt, 16'd0);
    repeat (2) step();
    #2 reset = 1'b1;
    step();
    frame_ready = 1'b1;

    // good frame, consumer ready
    send_frame(F1, 8'h08);
    chk("t1_valid", frame_valid, 1'b1);
    chk("t1_data", frame_data, 64'h0102030405060708);
    chk("t1_model_data", m_hd, 64'h0102030405060708);
    chk("t1_good", good_cnt, 16'd1);
    step();
    chk("t1_valid_clear", frame_valid, 1'b0);

    // bad checksum, then good frame
    send_frame(F1, 8'h09);
    chk("t2_crc", crc_err, 1'b1);
    chk("t2_valid", frame_valid, 1'b0);
    chk("t2_err", err_cnt, 16'd1);
    step();
    chk("t2_crc_pulse", crc_err, 1'b0);
    send_frame(F1, 8'h08);
    chk("t2_good", good_cnt, 16'd2);

    // timeout: 8680 idle clocks after the last byte
    send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    repeat (TMO - 1) step();
    chk("t3_no_tmo_yet", timeout_err, 1'b0);
    step();
    chk("t3_tmo", timeout_err, 1'b1);
    chk("t3_model_tmo", e_tmo, 1'b1);
    chk("t3_err", err_cnt, 16'd2);
    step();
    chk("t3_tmo_pulse", timeout_err, 1'b0);

    // bytes arriving just before / exactly at terminal count keep the frame alive
    send_byte(8'hA5, 1'b0); send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    repeat (TMO - 2) step();
    send_byte(8'h44, 1'b0);
    chk("t3b_no_tmo", timeout_err, 1'b0);
    repeat (TMO - 1) step();
    send_byte(8'h55, 1'b0);
    chk("t3c_no_tmo", timeout_err, 1'b0);
    send_byte(8'h66, 1'b0); send_byte(8'h77, 1'b0); send_byte(8'h88, 1'b0); send_byte(8'h88, 1'b0);
    chk("t3c_data", frame_data, 64'h1122334455667788);
    chk("t3c_good", good_cnt, 16'd3);
    step();

    // overflow with consumer stalled
    frame_ready = 1'b0;
    send_frame(F1, 8'h08);
    chk("t4_valid", frame_valid, 1'b1);
    chk("t4_good", good_cnt, 16'd4);
    send_frame(F2, 8'h80);
    chk("t4_ovf", overflow_err, 1'b1);
    chk("t4_held", frame_data, 64'h0102030405060708);
    chk("t4_good_same", good_cnt, 16'd4);
    chk("t4_err", err_cnt, 16'd3);
    step();
    chk("t4_ovf_pulse", overflow_err, 1'b0);
    frame_ready = 1'b1;
    step();
    frame_ready = 1'b0;
    chk("t4_xfer", frame_valid, 1'b0);
    step();
    chk("t4_empty", frame_valid, 1'b0);

    // junk before sync, sync value inside payload, framing error on P3
    frame_ready = 1'b1;
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
    send_frame(64'hA5A5000000000001, 8'h01);
    chk("t5_data", frame_data, 64'hA5A5000000000001);
    chk("t5_good", good_cnt, 16'd5);
    send_byte(8'hA5, 1'b0); send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    send_byte(8'h33, 1'b1);
    chk("t5_link", link_err, 1'b1);
    chk("t5_err", err_cnt, 16'd4);
    send_byte(8'h04, 1'b0);
    chk("t5_link_pulse", link_err, 1'b0);

    // asynchronous reset mid-payload with a held frame
    frame_ready = 1'b0;
    send_frame(F1, 8'h08);
    chk("t6_valid", frame_valid, 1'b1);
    send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", frame_valid, 1'b0);
    chk("t6_rst_data", frame_data, 64'h0);
    chk("t6_rst_good", good_cnt, 16'd0);
    chk("t6_rst_err", err_cnt, 16'd0);
    repeat (2) step();
    @(negedge clk);
    #2 reset = 1'b1;
    step();
    frame_ready = 1'b1;
    send_frame(F2, 8'h80);
    chk("t6_after_valid", frame_valid, 1'b1);
    chk("t6_after_data", frame_data, 64'h1020304050607080);
    chk("t6_after_good", good_cnt, 16'd1);

    // randomized traffic
    rnd_ready = 1'b1;
    long_left = 3;
    for (int f = 0; f < 250; f++) begin
      kind = int'($urandom_range(0, 9));
      p = {$urandom, $urandom};
      ck = xsum(p);
      if (kind == 5) ck = ck ^ 8'($urandom_range(1, 255));
      if (kind == 6) begin
        repeat ($urandom_range(1, 4)) send_byte(8'($urandom), 1'b0);
      end else begin
        pos = (kind == 7) ? int'($urandom_range(0, 9)) : 99;
        for (int i = 0; i < 10; i++) begin
          if (kind == 8 && i == 4) begin
            if (long_left > 0) begin
              long_left--;
              repeat (TMO - 1 + int'($urandom_range(0, 1))) step();
            end
          end
          if (i == 0) send_byte(8'hA5, 1'(pos == 0));
          else if (i < 9) send_byte(p[63-8*(i-1) -: 8], 1'(pos == i));
          else send_byte(ck, 1'(pos == i));
          gap = (kind == 9) ? 0 : int'($urandom_range(0, 2));
          repeat (gap) step();
        end
      end
    end
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
